pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//  Sequences the VGA pixel-clock PLL: pulses its reset, waits for lock within a timeout,
//  requires lock to stay stable, then releases reset to the VGA timing/pixel logic.
//  Retries the PLL on lock timeout or lock loss, and enters FAULT after MAX_RETRY failed retries.
//  Runs on the 50 MHz board reference clock and sits beside the PLL wrapper at top level.
// PARAMETERS
//  RST_CYCLES     16     refclk cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT   50000  refclk cycles allowed in WAIT_LOCK before a retry (1 ms)
//  STABLE_CYCLES  1024   consecutive lock_s=1 cycles required before release
//  MAX_RETRY      3      retries allowed after the first attempt before FAULT
//  CNT_W          16     cycle-counter width; RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES must each be <= 2^CNT_W
//  RETRY_W        2      retry_cnt width; MAX_RETRY < 2^RETRY_W
// PORTS
//  refclk     in   1        board reference clock, sole clock
//  reset      in   1        asynchronous, active-high reset
//  pll_lock   in   1        PLL lock, asynchronous to refclk
//  rearm      in   1        single-cycle pulse; leaves FAULT, ignored in other states
//  pll_rst    out  1        reset to the PLL, active-high
//  sys_rst    out  1        reset to VGA logic, active-high
//  ready      out  1        1 only in RUN
//  fault      out  1        1 only in FAULT
//  retry_cnt  out  RETRY_W  retries in the current bring-up
//  state_dbg  out  2        0=PLL_RST 1=WAIT_LOCK 2=STABLE 3=RUN; FAULT reported as 0 with fault=1
// BEHAVIOUR
//  - One clock domain; reset is asynchronous and active-high.
//  - pll_lock passes through a 2-flop synchronizer to give lock_s. No other input is synchronized.
//  - Reset values: state=PLL_RST, cnt=0, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_cnt=0.
//    These apply immediately on reset assertion, from any state.
//  - All outputs are registered and decoded from the next state.
//    Each output changes on the same edge that the state register changes.
//  - cnt is cleared on every state change and increments by 1 per cycle otherwise.
//  - PLL_RST: pll_rst=1, sys_rst=1.
//    At cnt==RST_CYCLES-1, go to WAIT_LOCK. pll_rst is therefore high for exactly RST_CYCLES cycles per attempt.
//  - WAIT_LOCK: pll_rst=0.
//    If lock_s=1, go to STABLE.
//    Otherwise, at cnt==LOCK_TIMEOUT-1, take the RETRY path.
//  - STABLE: if lock_s=0, take the RETRY path. Lock loss takes priority over the count.
//    Otherwise, at cnt==STABLE_CYCLES-1, go to RUN.
//  - RUN: sys_rst=0, ready=1. retry_cnt is cleared on the entry edge.
//    If lock_s=0, go to PLL_RST without incrementing retry_cnt.
//    sys_rst is 1 on that same edge, which is the 3rd refclk edge after pll_lock falls.
//  - RETRY path:
//    If retry_cnt==MAX_RETRY, go to FAULT.
//    Otherwise, retry_cnt += 1 and go to PLL_RST.
//  - FAULT: pll_rst=1 (PLL parked in reset), sys_rst=1, fault=1, ready=0. retry_cnt is held.
//    rearm=1 -> go to PLL_RST and clear retry_cnt to 0.
//  - A timeout edge and lock_s rising on the same cycle in WAIT_LOCK resolves to STABLE (lock wins).
//  - retry_cnt saturates at MAX_RETRY and never wraps.
//  - sys_rst is synchronous to refclk only. Each consuming domain re-synchronizes it.
// TESTING  (bench params: RST_CYCLES=4 LOCK_TIMEOUT=20 STABLE_CYCLES=8 MAX_RETRY=2)
//  1. Nominal: release reset, raise pll_lock 10 cycles later and hold it.
//     -> pll_rst=1 for the first 4 cycles.
//     -> ready=1 and sys_rst=0 exactly 10 edges after the first edge that samples pll_lock=1.
//     -> retry_cnt=0.
//  2. pll_lock held 0.
//     -> 3 attempts of 24 cycles each.
//     -> fault=1 on edge 72 after reset release, with retry_cnt=2, pll_rst=1, sys_rst=1.
//     -> Held there indefinitely.
//  3. In STABLE, drop pll_lock for 3 cycles at cnt=5.
//     -> Back to PLL_RST with retry_cnt=1 and ready still 0.
//     -> A later solid lock reaches RUN with retry_cnt cleared to 0.
//  4. In RUN, drop pll_lock.
//     -> sys_rst=1 and ready=0 on the 3rd edge; retry_cnt stays 0.
//     -> Full resequence, and ready returns after relock.
//  5. In FAULT, pulse rearm for 1 cycle.
//     -> fault=0, retry_cnt=0, state PLL_RST.
//     -> A rearm pulse in RUN causes no output change.
//  6. Assert reset mid-STABLE (async, between edges).
//     -> pll_rst=1, sys_rst=1, ready=0 before the next edge.
//     -> After release, the sequence restarts from PLL_RST.

Source files
------------

// File: rtl/pll_lock_sequencer_if.sv
// Handshake bundle between the PLL lock sequencer and its surroundings:
// PLL lock/rearm inputs and the PLL/VGA reset, status and debug outputs.
interface pll_lock_sequencer_if #(
   parameter int RETRY_W = 2
);
   logic               pll_lock;
   logic               rearm;
   logic               pll_rst;
   logic               sys_rst;
   logic               ready;
   logic               fault;
   logic [RETRY_W-1:0] retry_cnt;
   logic [1:0]         state_dbg;

   modport master (
      input  pll_lock,
      input  rearm,
      output pll_rst,
      output sys_rst,
      output ready,
      output fault,
      output retry_cnt,
      output state_dbg
   );

   modport slave (
      output pll_lock,
      output rearm,
      input  pll_rst,
      input  sys_rst,
      input  ready,
      input  fault,
      input  retry_cnt,
      input  state_dbg
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Brings up the VGA pixel-clock PLL: pulses its reset, waits for a stable lock,
// then releases the VGA logic; retries on timeout/lock loss and parks in FAULT.
module pll_lock_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRY     = 3,
   parameter int CNT_W         = 16,
   parameter int RETRY_W       = 2
) (
   input  logic                  refclk,
   input  logic                  reset,
   pll_lock_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               lock_meta_q, lock_s_q;
   logic               pll_rst_q, sys_rst_q, ready_q, fault_q;
   logic [1:0]         state_dbg_q;

   // FAULT is reported with the PLL_RST code; the fault flag tells them apart
   function automatic logic [1:0] dbg_code(input state_e s);
      logic [1:0] code;
      case (s)
         ST_WAIT_LOCK: code = 2'd1;
         ST_STABLE:    code = 2'd2;
         ST_RUN:       code = 2'd3;
         default:      code = 2'd0;
      endcase
      return code;
   endfunction

   // Two-flop synchronizer for the asynchronous PLL lock
   always_ff @(posedge refclk or posedge reset) begin
      if (reset) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= bus.pll_lock;
         lock_s_q    <= lock_meta_q;
      end
   end

   // Next-state, retry and cycle-counter decode
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      case (state_q)
         ST_PLL_RST: begin
            if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            else                   state_d = ST_PLL_RST;
         end
         ST_WAIT_LOCK: begin
            if (lock_s_q) begin
               state_d = ST_STABLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               if (retry_q >= RETRY_MAX) begin
                  state_d = ST_FAULT;
               end else begin
                  state_d = ST_PLL_RST;
                  retry_d = retry_q + RETRY_W'(1);
               end
            end else begin
               state_d = ST_WAIT_LOCK;
            end
         end
         ST_STABLE: begin
            if (!lock_s_q) begin
               if (retry_q >= RETRY_MAX) begin
                  state_d = ST_FAULT;
               end else begin
                  state_d = ST_PLL_RST;
                  retry_d = retry_q + RETRY_W'(1);
               end
            end else if (cnt_q == STABLE_LAST) begin
               state_d = ST_RUN;
               retry_d = '0;
            end else begin
               state_d = ST_STABLE;
            end
         end
         ST_RUN: begin
            // Lock loss in RUN is not a bring-up failure, so no retry is charged
            if (!lock_s_q) state_d = ST_PLL_RST;
            else           state_d = ST_RUN;
         end
         ST_FAULT: begin
            if (bus.rearm) begin
               state_d = ST_PLL_RST;
               retry_d = '0;
            end else begin
               state_d = ST_FAULT;
            end
         end
         default: begin
            state_d = ST_PLL_RST;
            retry_d = '0;
         end
      endcase

      if (state_d != state_q) cnt_d = '0;
      else                    cnt_d = cnt_q + CNT_W'(1);
   end

   // State, counters and outputs, all decoded from the next state
   always_ff @(posedge refclk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_PLL_RST;
         cnt_q       <= '0;
         retry_q     <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_q   <= 1'b1;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
         state_dbg_q <= 2'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         pll_rst_q   <= (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
         sys_rst_q   <= (state_d != ST_RUN);
         ready_q     <= (state_d == ST_RUN);
         fault_q     <= (state_d == ST_FAULT);
         state_dbg_q <= dbg_code(state_d);
      end
   end

   assign bus.pll_rst   = pll_rst_q;
   assign bus.sys_rst   = sys_rst_q;
   assign bus.ready     = ready_q;
   assign bus.fault     = fault_q;
   assign bus.retry_cnt = retry_q;
   assign bus.state_dbg = state_dbg_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters;
// every expectation is hand-derived edge counts from reset release or lock changes.
module tb_pll_lock_sequencer;

   localparam int RST_CYCLES    = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int STABLE_CYCLES = 8;
   localparam int MAX_RETRY     = 2;
   localparam int CNT_W         = 16;
   localparam int RETRY_W       = 2;

   logic refclk;
   logic reset;
   int   n_checks;
   int   n_fail;

   pll_lock_sequencer_if #(.RETRY_W(RETRY_W)) bus ();

   pll_lock_sequencer #(
      .RST_CYCLES    (RST_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .STABLE_CYCLES (STABLE_CYCLES),
      .MAX_RETRY     (MAX_RETRY),
      .CNT_W         (CNT_W),
      .RETRY_W       (RETRY_W)
   ) dut (
      .refclk (refclk),
      .reset  (reset),
      .bus    (bus.master)
   );

   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [1:0] st, input logic prst,
                            input logic srst, input logic rdy, input logic flt,
                            input logic [1:0] rc);
      check({tag, ".state"},   {30'd0, bus.state_dbg}, {30'd0, st});
      check({tag, ".pll_rst"}, {31'd0, bus.pll_rst},   {31'd0, prst});
      check({tag, ".sys_rst"}, {31'd0, bus.sys_rst},   {31'd0, srst});
      check({tag, ".ready"},   {31'd0, bus.ready},     {31'd0, rdy});
      check({tag, ".fault"},   {31'd0, bus.fault},     {31'd0, flt});
      check({tag, ".retry"},   {30'd0, bus.retry_cnt}, {30'd0, rc});
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      reset        = 1'b1;
      bus.pll_lock = 1'b0;
      bus.rearm    = 1'b0;
      tick(2);
      check_all("reset", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

      // 1. nominal bring-up; edge counts from reset release
      reset = 1'b0;
      tick(3);
      check_all("nom.e3", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      tick(1);
      check_all("nom.e4", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      tick(6);
      bus.pll_lock = 1'b1;
      tick(1);                          // edge 11 samples pll_lock=1
      tick(9);
      check_all("nom.e20", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      tick(1);
      check_all("nom.e21", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

      // 5b. rearm outside FAULT is ignored
      bus.rearm = 1'b1;
      tick(1);
      bus.rearm = 1'b0;
      check_all("rearm_run", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      tick(2);
      check_all("rearm_run2", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

      // 4. lock loss in RUN: reset on the 3rd edge, then relock
      bus.pll_lock = 1'b0;
      tick(2);
      check_all("runloss.e2", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      tick(1);
      check_all("runloss.e3", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      bus.pll_lock = 1'b1;
      tick(4);
      check_all("relock.wait", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      tick(1);
      check_all("relock.stable", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      tick(7);
      check_all("relock.e12", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      tick(1);
      check_all("relock.run", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

      // 3. glitch in STABLE at cnt=5 charges one retry
      bus.pll_lock = 1'b0;
      tick(3);                          // P: back in PLL_RST
      bus.pll_lock = 1'b1;
      tick(10);                         // P+10: STABLE, cnt=5
      check_all("glitch.cnt5", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      bus.pll_lock = 1'b0;
      tick(2);
      check_all("glitch.e12", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      tick(1);
      check_all("glitch.retry", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
      bus.pll_lock = 1'b1;
      tick(4);
      check_all("glitch.wait", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
      tick(1);
      check_all("glitch.stable", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
      tick(8);
      check_all("glitch.run", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

      // 6. async reset in the middle of STABLE
      bus.pll_lock = 1'b0;
      tick(3);
      bus.pll_lock = 1'b1;
      tick(7);
      check_all("midrst.pre", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      #2;
      reset = 1'b1;
      #1;
      check_all("midrst.async", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      #1;
      reset = 1'b0;
      tick(3);
      check_all("midrst.e3", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      tick(1);
      check_all("midrst.e4", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      tick(1);
      check_all("midrst.e5", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      tick(8);
      check_all("midrst.e13", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

      // 2. lock never arrives: three 24-cycle attempts then FAULT at edge 72
      reset        = 1'b1;
      bus.pll_lock = 1'b0;
      tick(1);
      reset = 1'b0;
      tick(23);
      check_all("nolock.e23", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      tick(1);
      check_all("nolock.e24", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
      tick(24);
      check_all("nolock.e48", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
      tick(23);
      check_all("nolock.e71", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
      tick(1);
      check_all("nolock.e72", 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2);
      tick(30);
      check_all("fault.hold", 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2);

      // 5. rearm leaves FAULT and restarts the sequence
      bus.rearm = 1'b1;
      tick(1);
      bus.rearm = 1'b0;
      check_all("rearm", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      tick(3);
      check_all("rearm.e3", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      tick(1);
      check_all("rearm.e4", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
